// File: rtl/dma_ext_port_arbiter.sv
// rtl/dma_ext_port_arbiter.sv - two-channel OBI master arbiter with in-order response routing
module dma_ext_port_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [1:0]                          ch_req_i,
   output logic [1:0]                          ch_gnt_o,
   input  logic [2*ADDR_WIDTH-1:0]             ch_addr_i,
   input  logic [1:0]                          ch_we_i,
   input  logic [2*(DATA_WIDTH/8)-1:0]         ch_be_i,
   input  logic [2*DATA_WIDTH-1:0]             ch_wdata_i,
   output logic [1:0]                          ch_rvalid_o,
   output logic [DATA_WIDTH-1:0]               ch_rdata_o,
   output logic                                ext_req_o,
   input  logic                                ext_gnt_i,
   output logic [ADDR_WIDTH-1:0]               ext_addr_o,
   output logic                                ext_we_o,
   output logic [DATA_WIDTH/8-1:0]             ext_be_o,
   output logic [DATA_WIDTH-1:0]               ext_wdata_o,
   input  logic                                ext_rvalid_i,
   input  logic [DATA_WIDTH-1:0]               ext_rdata_i,
   output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
   output logic                                err_o
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int CW = PW + 1;

   logic [MAX_OUTSTANDING-1:0] id_mem;
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic [CW-1:0]              count;
   logic                       lock;
   logic                       lock_id;
   logic                       prio;
   logic                       err_q;

   logic sel;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic head_id;

   // A stalled request keeps its channel selected so the address phase stays stable.
   always_comb begin
      sel = prio;
      if (lock) begin
         sel = lock_id;
      end else if (ch_req_i == 2'b01) begin
         sel = 1'b0;
      end else if (ch_req_i == 2'b10) begin
         sel = 1'b1;
      end
   end

   assign full  = (count == CW'(MAX_OUTSTANDING));
   assign empty = (count == '0);

   assign ext_req_o   = ch_req_i[sel] & ~full;
   assign ext_addr_o  = sel ? ch_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : ch_addr_i[ADDR_WIDTH-1:0];
   assign ext_we_o    = sel ? ch_we_i[1] : ch_we_i[0];
   assign ext_be_o    = sel ? ch_be_i[2*BW-1:BW] : ch_be_i[BW-1:0];
   assign ext_wdata_o = sel ? ch_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : ch_wdata_i[DATA_WIDTH-1:0];

   assign push     = ext_req_o & ext_gnt_i;
   assign ch_gnt_o = {push & sel, push & ~sel};

   assign pop         = ext_rvalid_i & ~empty;
   assign head_id     = id_mem[rd_ptr];
   assign ch_rvalid_o = {pop & head_id, pop & ~head_id};
   assign ch_rdata_o  = ext_rdata_i;

   assign outstanding_o = count;
   assign err_o         = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_mem  <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         lock    <= 1'b0;
         lock_id <= 1'b0;
         prio    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (push) begin
            id_mem[wr_ptr] <= sel;
            wr_ptr         <= wr_ptr + PW'(1);
            prio           <= ~sel;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // Clears on handshake and also when the locked channel withdraws its request.
         lock <= ext_req_o & ~ext_gnt_i;
         if (ext_req_o & ~ext_gnt_i) begin
            lock_id <= sel;
         end
         if (ext_rvalid_i & empty) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dma_ext_port_arbiter.sv
// tb/tb_dma_ext_port_arbiter.sv - self-checking bench for dma_ext_port_arbiter
module tb_dma_ext_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = DW / 8;
   localparam int MAXO = 4;
   localparam int CW   = $clog2(MAXO) + 1;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic [1:0]        ch_req;
   logic [1:0]        ch_gnt;
   logic [2*AW-1:0]   ch_addr;
   logic [1:0]        ch_we;
   logic [2*BW-1:0]   ch_be;
   logic [2*DW-1:0]   ch_wdata;
   logic [1:0]        ch_rvalid;
   logic [DW-1:0]     ch_rdata;
   logic              ext_req;
   logic              ext_gnt;
   logic [AW-1:0]     ext_addr;
   logic              ext_we;
   logic [BW-1:0]     ext_be;
   logic [DW-1:0]     ext_wdata;
   logic              ext_rvalid;
   logic [DW-1:0]     ext_rdata;
   logic [CW-1:0]     outstanding;
   logic              err;

   always #5 clk = ~clk;

   dma_ext_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .ch_req_i(ch_req), .ch_gnt_o(ch_gnt), .ch_addr_i(ch_addr), .ch_we_i(ch_we),
      .ch_be_i(ch_be), .ch_wdata_i(ch_wdata), .ch_rvalid_o(ch_rvalid), .ch_rdata_o(ch_rdata),
      .ext_req_o(ext_req), .ext_gnt_i(ext_gnt), .ext_addr_o(ext_addr), .ext_we_o(ext_we),
      .ext_be_o(ext_be), .ext_wdata_o(ext_wdata), .ext_rvalid_i(ext_rvalid),
      .ext_rdata_i(ext_rdata), .outstanding_o(outstanding), .err_o(err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queue of issuing channel ids in issue order.
   int   idq[$];
   int   m_prio;
   bit   m_lock;
   int   m_lock_ch;
   bit   m_err;
   int   e_sel;
   logic e_ereq;

   typedef struct {
      logic [1:0] req;
      logic       gnt;
      logic       rv;
      logic       ereq;
      logic [1:0] gnt_o;
      logic [1:0] rv_o;
      int         out;
      logic       err;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      idq.delete();
      m_prio    = 0;
      m_lock    = 0;
      m_lock_ch = 0;
      m_err     = 0;
   endtask

   // Called just after inputs are driven on the falling edge.
   task automatic check_cycle();
      logic [1:0] e_gnt;
      logic [1:0] e_rv;
      #1;
      if (m_lock)                e_sel = m_lock_ch;
      else if (ch_req == 2'b01)  e_sel = 0;
      else if (ch_req == 2'b10)  e_sel = 1;
      else                       e_sel = m_prio;
      e_ereq = ch_req[e_sel] && (idq.size() < MAXO);
      e_gnt  = (e_ereq && ext_gnt) ? ((e_sel == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_rv   = (ext_rvalid && idq.size() > 0) ? ((idq[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("ext_req", ext_req, e_ereq);
      chk("ch_gnt", ch_gnt, e_gnt);
      chk("ch_rvalid", ch_rvalid, e_rv);
      chk("ch_rdata", ch_rdata, ext_rdata);
      chk("outstanding", outstanding, idq.size());
      chk("err", err, m_err);
      if (e_ereq) begin
         chk("ext_addr", ext_addr, ch_addr[e_sel*AW +: AW]);
         chk("ext_we", ext_we, ch_we[e_sel]);
         chk("ext_be", ext_be, ch_be[e_sel*BW +: BW]);
         chk("ext_wdata", ext_wdata, ch_wdata[e_sel*DW +: DW]);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (ext_rvalid) begin
         if (idq.size() > 0) idq.delete(0);
         else                m_err = 1;
      end
      if (e_ereq && ext_gnt) begin
         idq.push_back(e_sel);
         m_prio = 1 - e_sel;
         m_lock = 0;
      end else if (e_ereq) begin
         m_lock    = 1;
         m_lock_ch = e_sel;
      end else begin
         m_lock = 0;
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
      ch_req     = req;
      ext_gnt    = gnt;
      ext_rvalid = rv;
      ext_rdata  = rd;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err", err, 1'b0);
      model_reset();
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 0, 1'b0};
      tbl[1]  = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 0, 1'b0};
      tbl[2]  = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 0, 1'b0};
      tbl[3]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 0, 1'b0};
      tbl[4]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1, 1'b0};
      tbl[5]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2, 1'b0};
      tbl[6]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1, 1'b0};
      tbl[7]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 0, 1'b0};
      tbl[8]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1, 1'b0};
      tbl[9]  = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 2, 1'b0};
      tbl[10] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 2, 1'b0};
      tbl[11] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 3, 1'b0};
      tbl[12] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 4, 1'b0};
      tbl[13] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 4, 1'b0};
      tbl[14] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 3, 1'b0};
      tbl[15] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4, 1'b0};
      tbl[16] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 4, 1'b0};
      tbl[17] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 3, 1'b0};
      tbl[18] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2, 1'b0};
      tbl[19] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1, 1'b0};
      tbl[20] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0};
      tbl[21] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b1};

      rst_ni   = 1'b0;
      ch_addr  = {32'h0000_0100, 32'h0000_0200};
      ch_we    = 2'b00;
      ch_be    = 8'hFF;
      ch_wdata = '0;
      drive(2'b00, 1'b0, 1'b0, '0);
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ext_req", ext_req, 1'b0);
      chk("reset_ch_gnt", ch_gnt, 2'b00);
      chk("reset_ch_rvalid", ch_rvalid, 2'b00);
      chk("reset_outstanding", outstanding, 0);
      chk("reset_err", err, 1'b0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Lock/stall, contention, full FIFO, drain, spurious response.
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, 32'hA0 + i);
         check_cycle();
         chk($sformatf("tbl%0d_ext_req", i), ext_req, tbl[i].ereq);
         chk($sformatf("tbl%0d_ch_gnt", i), ch_gnt, tbl[i].gnt_o);
         chk($sformatf("tbl%0d_ch_rvalid", i), ch_rvalid, tbl[i].rv_o);
         chk($sformatf("tbl%0d_outstanding", i), outstanding, tbl[i].out);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
         if (i < 4) chk($sformatf("tbl%0d_lock_addr", i), ext_addr, 32'h100);
         advance();
      end

      // Reset mid-flight: two outstanding, then late response flags an error.
      do_reset();
      drive(2'b11, 1'b1, 1'b0, '0);
      check_cycle();
      chk("mid_first_gnt", ch_gnt, 2'b01);
      advance();
      check_cycle();
      chk("mid_second_gnt", ch_gnt, 2'b10);
      advance();
      drive(2'b00, 1'b0, 1'b0, '0);
      check_cycle();
      chk("mid_outstanding", outstanding, 2);
      rst_ni = 1'b0;
      #1;
      chk("mid_async_clear", outstanding, 0);
      model_reset();
      @(negedge clk);
      rst_ni = 1'b1;
      drive(2'b00, 1'b0, 1'b1, 32'h55);
      check_cycle();
      chk("late_rvalid", ch_rvalid, 2'b00);
      advance();
      drive(2'b11, 1'b1, 1'b0, '0);
      check_cycle();
      chk("late_err", err, 1'b1);
      chk("prio_after_reset", ch_gnt, 2'b01);
      advance();

      do_reset();
      for (int n = 0; n < 600; n++) begin
         ch_req[0]  = ($urandom_range(0, 9) < 7);
         ch_req[1]  = ($urandom_range(0, 9) < 7);
         ext_gnt    = ($urandom_range(0, 9) < 6);
         ext_rvalid = (idq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
         ext_rdata  = $urandom;
         ch_addr    = {$urandom, $urandom};
         ch_we      = 2'($urandom);
         ch_be      = 8'($urandom);
         ch_wdata   = {$urandom, $urandom};
         check_cycle();
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_ext_port_arbiter.md
Name: dma_ext_port_arbiter

Overview:
Shares one external OBI master port between the instruction DMA channel (port 0) and the data DMA channel (port 1) inside the scratchpad controller. It arbitrates address phases round-robin and keeps OBI address-phase stability while a request is waiting. It tracks outstanding transactions in an in-order ID FIFO and steers each response back to the channel that issued it.

Parameters:
ADDR_WIDTH, 32, OBI address width
DATA_WIDTH, 32, OBI data width; be width is DATA_WIDTH/8
MAX_OUTSTANDING, 4, depth of the response-ID FIFO (power of 2, >=2)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
ch_req_i  input  2  per-channel OBI req, bit0 instr, bit1 data
ch_gnt_o  output  2  per-channel OBI gnt
ch_addr_i  input  2xADDR_WIDTH  per-channel address
ch_we_i  input  2  per-channel write enable
ch_be_i  input  2xDATA_WIDTH/8  per-channel byte enables
ch_wdata_i  input  2xDATA_WIDTH  per-channel write data
ch_rvalid_o  output  2  per-channel response valid
ch_rdata_o  output  DATA_WIDTH  response data, broadcast to both channels
ext_req_o  output  1  external OBI req
ext_gnt_i  input  1  external OBI gnt
ext_addr_o  output  ADDR_WIDTH  external address
ext_we_o  output  1  external write enable
ext_be_o  output  DATA_WIDTH/8  external byte enables
ext_wdata_o  output  DATA_WIDTH  external write data
ext_rvalid_i  input  1  external response valid
ext_rdata_i  input  DATA_WIDTH  external response data
outstanding_o  output  $clog2(MAX_OUTSTANDING)+1  number of in-flight transactions
err_o  output  1  sticky flag: response received with no transaction outstanding

Behaviour:
- Reset is asynchronous on rst_ni low. State after reset: FIFO empty, outstanding_o=0, err_o=0, lock cleared, priority pointer = channel 0.
- Outputs are combinational from state and inputs. With no requests active, ext_req_o=0, ch_gnt_o=0 and ch_rvalid_o=0 after reset.
- Selection:
  - If lock is set, sel = locked channel.
  - Otherwise, if only one ch_req_i bit is set, sel = that channel.
  - If both are set, sel = priority pointer.
- full = (count == MAX_OUTSTANDING). Forwarding uses the registered count only; a pop in the same cycle does not unblock a push.
- Request forwarding:
  - ext_req_o = ch_req_i[sel] & ~full.
  - ext_addr/we/be/wdata are muxed from sel.
  - ch_gnt_o[sel] = ext_gnt_i & ext_req_o; the other gnt bit is 0.
- Lock: set with lock_id=sel when ext_req_o=1 and ext_gnt_i=0. Cleared on the handshake. The selection is held until gnt even if the other channel has priority.
- Accepted transaction (ext_req_o & ext_gnt_i):
  - Push sel into the ID FIFO.
  - Priority pointer := ~sel.
  - Lock is cleared.
  - There is no dead cycle; a new handshake can occur every cycle.
- Response: on ext_rvalid_i with FIFO not empty:
  - ch_rvalid_o[head_id] = 1, ch_rdata_o = ext_rdata_i.
  - Pop the FIFO in the same cycle, so response latency through the block is 0 cycles.
- Response with FIFO empty: ch_rvalid_o stays 0, err_o is set and stays 1 until reset, count is unchanged.
- Simultaneous push and pop: count is unchanged and both FIFO pointers advance. The FIFO head/tail pointers wrap modulo MAX_OUTSTANDING.
- ch_rdata_o = ext_rdata_i at all times; channels qualify it with their rvalid.
- A channel that drops req before gnt violates OBI. This is not checked; the lock still clears when that channel's req drops.
- Reset during in-flight transactions discards the FIFO contents. Any late ext_rvalid_i after reset raises err_o.

Test Plan:
- Single channel: ch0 issues 3 back-to-back reads, ext_gnt_i=1, rvalid 2 cycles later with rdata 0xA0,0xA1,0xA2 -> ch_gnt_o=01 each cycle, ch_rvalid_o[0] pulses 3 times with matching data, outstanding_o peaks at 2 and returns to 0.
- Contention: both channels request continuously, gnt=1 -> grants alternate ch0,ch1,ch0,ch1 starting with ch0 after reset; responses route per issue order.
- Stall and lock: ch1 alone asserts req at addr 0x100 with gnt=0 for 3 cycles, ch0 raises req in cycle 2 -> ext_addr_o stays 0x100 and ext_req_o stays 1 until gnt; ch1 is granted first, then ch0.
- Full: MAX_OUTSTANDING=4, 4 grants without rvalid -> ext_req_o=0 and outstanding_o=4. A cycle with both rvalid and a pending req still gives no grant; the next cycle grants and outstanding_o=4.
- Spurious response: ext_rvalid_i=1 with outstanding_o=0 -> ch_rvalid_o=00, err_o=1 and held until rst_ni low.
- Reset mid-flight: 2 outstanding, pulse rst_ni low -> outstanding_o=0 and priority returns to ch0; a subsequent rvalid sets err_o.
